// File: rtl/pc_out_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | PCPackPkg : shared PC word-packing constants, grant/state types, helpers    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package PCPackPkg;

    localparam int NPCcode  = 8;
    localparam int NPCdata  = 24;
    localparam int NPCroute = 10;
    localparam int NPC_W    = NPCroute + NPCcode + NPCdata;

    localparam logic [NPCcode-1:0] FPGA_SPIKE_CODE = 8'd13;
    localparam logic [NPCcode-1:0] FPGA_HB_CODE    = 8'd14;
    localparam int                 GO_HOME_rt      = -512;

    typedef enum logic [1:0] {
        GNT_BD     = 2'd0,
        GNT_FPGA   = 2'd1,
        GNT_GLOBAL = 2'd2,
        GNT_NONE   = 2'd3
    } grant_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } state_e;

    // Round-robin successor over the three inputs BD -> FPGA -> Global -> BD.
    function automatic logic [1:0] rr_next(input logic [1:0] g);
        return (g >= 2'd2) ? 2'd0 : g + 2'd1;
    endfunction

    function automatic logic is_pair_code(input logic [NPCcode-1:0] code);
        return (code == FPGA_SPIKE_CODE) || (code == FPGA_HB_CODE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_out_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_out_scheduler_if : three packed input channels, PC output, debug grant   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface pc_out_scheduler_if #(
    parameter int W = PCPackPkg::NPC_W
);
    logic [W-1:0] bd_d;
    logic         bd_v;
    logic         bd_a;
    logic [W-1:0] fpga_d;
    logic         fpga_v;
    logic         fpga_a;
    logic [W-1:0] glob_d;
    logic         glob_v;
    logic         glob_a;
    logic [W-1:0] out_d;
    logic         out_v;
    logic         out_a;
    logic [1:0]   grant;

    modport master (
        input  bd_d, bd_v, fpga_d, fpga_v, glob_d, glob_v, out_a,
        output bd_a, fpga_a, glob_a, out_d, out_v, grant
    );

    modport slave (
        output bd_d, bd_v, fpga_d, fpga_v, glob_d, glob_v, out_a,
        input  bd_a, fpga_a, glob_a, out_d, out_v, grant
    );
endinterface
`default_nettype wire

// File: rtl/pc_out_scheduler_rr_pick3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_pick3 : first valid request at or after the rotation pointer (3 inputs)  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module rr_pick3 (
    input  wire logic [1:0] ptr,
    input  wire logic [2:0] req,
    output logic            any,
    output logic [1:0]      sel
);
    import PCPackPkg::*;

    logic [1:0] c0;
    logic [1:0] c1;
    logic [1:0] c2;
    logic [3:0] req_ext;

    assign req_ext = {1'b0, req};
    assign c0      = (ptr == 2'd3) ? 2'd0 : ptr;
    assign c1      = rr_next(c0);
    assign c2      = rr_next(c1);
    assign any     = |req;

    always_comb begin
        sel = c0;
        if (req_ext[c0]) begin
            sel = c0;
        end else if (req_ext[c1]) begin
            sel = c1;
        end else if (req_ext[c2]) begin
            sel = c2;
        end
    end
endmodule
`default_nettype wire

// File: rtl/pc_out_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_out_scheduler : credit-based round-robin merge of BD/FPGA/Global words   |
// | onto the registered PC output, keeping FPGA 13/14 pairs contiguous. Rev 1.0 |
// +----------------------------------------------------------------------------+
module pc_out_scheduler #(
    parameter int NPCcode  = PCPackPkg::NPCcode,
    parameter int NPCdata  = PCPackPkg::NPCdata,
    parameter int NPCroute = PCPackPkg::NPCroute,
    parameter int W_BD     = 4,
    parameter int W_FPGA   = 2,
    parameter int W_GLOBAL = 2
) (
    input  wire logic          clk,
    input  wire logic          reset,
    pc_out_scheduler_if.master bus
);
    import PCPackPkg::*;

    localparam int W  = NPCroute + NPCcode + NPCdata;
    localparam int CW = 4;

    state_e        state_q, state_d;
    grant_e        gnt_q, gnt_d;
    logic [1:0]    ptr_q, ptr_d;
    logic          lock_q, lock_d;
    logic [CW-1:0] credit_q [3];
    logic [CW-1:0] credit_d [3];
    logic [W-1:0]  out_d_q, out_d_d;
    logic          out_v_q, out_v_d;

    logic               serving;
    logic               accept;
    logic               gnt_valid;
    logic [W-1:0]       gnt_data;
    logic [NPCcode-1:0] gnt_code;
    logic               xfer;
    logic [1:0]         pick_ptr;
    logic               pick_any;
    logic [1:0]         pick_sel;

    function automatic logic [CW-1:0] weight_of(input logic [1:0] sel);
        case (sel)
            2'd0:    weight_of = CW'(W_BD);
            2'd1:    weight_of = CW'(W_FPGA);
            default: weight_of = CW'(W_GLOBAL);
        endcase
    endfunction

    assign serving = (state_q == ST_SERVE);
    assign accept  = ~out_v_q | bus.out_a;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_data  = '0;
        case (gnt_q)
            GNT_BD:     begin gnt_valid = bus.bd_v;   gnt_data = bus.bd_d;   end
            GNT_FPGA:   begin gnt_valid = bus.fpga_v; gnt_data = bus.fpga_d; end
            GNT_GLOBAL: begin gnt_valid = bus.glob_v; gnt_data = bus.glob_d; end
            default:    begin gnt_valid = 1'b0;       gnt_data = '0;         end
        endcase
    end

    assign gnt_code = gnt_data[NPCdata +: NPCcode];
    assign xfer     = serving & gnt_valid & accept;

    // While serving, the next pick starts after the current grant so a direct
    // hand-over needs no IDLE cycle; from IDLE it starts at the stored pointer.
    assign pick_ptr = serving ? rr_next(gnt_q) : ptr_q;

    rr_pick3 u_pick (
        .ptr (pick_ptr),
        .req ({bus.glob_v, bus.fpga_v, bus.bd_v}),
        .any (pick_any),
        .sel (pick_sel)
    );

    assign bus.bd_a   = serving & (gnt_q == GNT_BD)     & accept;
    assign bus.fpga_a = serving & (gnt_q == GNT_FPGA)   & accept;
    assign bus.glob_a = serving & (gnt_q == GNT_GLOBAL) & accept;
    assign bus.out_d  = out_d_q;
    assign bus.out_v  = out_v_q;
    assign bus.grant  = gnt_q;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        lock_d   = lock_q;
        credit_d = credit_q;
        out_d_d  = out_d_q;
        out_v_d  = out_v_q & ~bus.out_a;

        if (xfer) begin
            out_d_d = gnt_data;
            out_v_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_d              = grant_e'(pick_sel);
                    credit_d[pick_sel] = weight_of(pick_sel);
                    state_d            = ST_SERVE;
                end
            end
            default: begin
                if (xfer && (credit_q[gnt_q] != '0)) begin
                    credit_d[gnt_q] = credit_q[gnt_q] - CW'(1);
                end
                if (xfer && (gnt_q == GNT_FPGA) && is_pair_code(gnt_code)) begin
                    lock_d = ~lock_q;
                end
                // The lock value after this cycle's toggle decides, so the
                // closing half of a pair releases the grant on its own edge.
                if (!lock_d && ((credit_d[gnt_q] == '0) || !gnt_valid)) begin
                    ptr_d = rr_next(gnt_q);
                    if (pick_any) begin
                        gnt_d              = grant_e'(pick_sel);
                        credit_d[pick_sel] = weight_of(pick_sel);
                    end else begin
                        gnt_d   = GNT_NONE;
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            gnt_q    <= GNT_NONE;
            ptr_q    <= 2'd0;
            lock_q   <= 1'b0;
            credit_q <= '{default: '0};
            out_d_q  <= '0;
            out_v_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            lock_q   <= lock_d;
            credit_q <= credit_d;
            out_d_q  <= out_d_d;
            out_v_q  <= out_v_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pc_out_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pc_out_scheduler : directed, table-driven bench for pc_out_scheduler     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_pc_out_scheduler;
    import PCPackPkg::*;

    localparam int W = NPC_W;

    typedef struct {
        logic       out_a;
        logic       exp_v;
        int         src;
        int         seq;
        logic [1:0] gnt;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pc_out_scheduler_if #(.W(W)) bus0 ();
    pc_out_scheduler_if #(.W(W)) bus1 ();

    pc_out_scheduler u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.master)
    );

    pc_out_scheduler #(.W_FPGA(1)) u_dut_p (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.master)
    );

    int          errors = 0;
    int          checks = 0;
    int          sq  [2][3];
    int          rem [2][3];
    logic [7:0]  fq0[$];
    logic [7:0]  fq1[$];
    logic        hold;
    int          spec_seq;
    logic [2:0]  ack0, tk0, ack1, tk1;
    logic [W-1:0] special;
    logic [W-1:0] got[$];
    logic [W-1:0] expw[$];
    vec_t        vt [17];

    function automatic logic [W-1:0] mk(input int src, input logic [7:0] code, input int seq);
        logic [9:0] r;
        r = 10'(src + 1);
        return {r, code, 24'(seq)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        bus0.bd_v   = (rem[0][0] > 0);
        bus0.bd_d   = (sq[0][0] == spec_seq) ? special : mk(0, 8'h00, sq[0][0]);
        bus0.fpga_v = (rem[0][1] > 0) && !hold;
        bus0.fpga_d = mk(1, (fq0.size() > 0) ? fq0[0] : 8'h00, sq[0][1]);
        bus0.glob_v = (rem[0][2] > 0);
        bus0.glob_d = mk(2, 8'h00, sq[0][2]);
        bus1.bd_v   = (rem[1][0] > 0);
        bus1.bd_d   = mk(0, 8'h00, sq[1][0]);
        bus1.fpga_v = (rem[1][1] > 0);
        bus1.fpga_d = mk(1, (fq1.size() > 0) ? fq1[0] : 8'h00, sq[1][1]);
        bus1.glob_v = (rem[1][2] > 0);
        bus1.glob_d = mk(2, 8'h00, sq[1][2]);
    endtask

    // Acks are sampled mid-cycle; sources advance just after the edge.
    task automatic cycle();
        @(negedge clk);
        ack0 = {bus0.glob_a, bus0.fpga_a, bus0.bd_a};
        tk0  = ack0 & {bus0.glob_v, bus0.fpga_v, bus0.bd_v};
        ack1 = {bus1.glob_a, bus1.fpga_a, bus1.bd_a};
        tk1  = ack1 & {bus1.glob_v, bus1.fpga_v, bus1.bd_v};
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (tk0[i]) begin sq[0][i]++; rem[0][i]--; end
            if (tk1[i]) begin sq[1][i]++; rem[1][i]--; end
        end
        if (tk0[1] && fq0.size() > 0) void'(fq0.pop_front());
        if (tk1[1] && fq1.size() > 0) void'(fq1.pop_front());
        drive();
    endtask

    task automatic clear_src();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 3; i++) begin
                sq[d][i]  = 0;
                rem[d][i] = 0;
            end
        fq0.delete();
        fq1.delete();
        hold     = 1'b0;
        spec_seq = -1;
    endtask

    task automatic do_reset();
        clear_src();
        drive();
        reset = 1'b0;
        repeat (2) cycle();
    endtask

    initial begin
        special = {10'h3FF, 8'h0D, 24'hABCDEF};
        //            out_a exp_v src seq gnt
        vt[0]  = '{1'b1, 1'b0, 0, 0, 2'd0};
        vt[1]  = '{1'b1, 1'b1, 0, 0, 2'd0};
        vt[2]  = '{1'b1, 1'b1, 0, 1, 2'd0};
        vt[3]  = '{1'b1, 1'b1, 0, 2, 2'd0};
        vt[4]  = '{1'b1, 1'b1, 0, 3, 2'd1};
        vt[5]  = '{1'b1, 1'b1, 1, 0, 2'd1};
        vt[6]  = '{1'b1, 1'b1, 1, 1, 2'd2};
        vt[7]  = '{1'b1, 1'b1, 2, 0, 2'd2};
        vt[8]  = '{1'b1, 1'b1, 2, 1, 2'd0};
        vt[9]  = '{1'b1, 1'b1, 0, 4, 2'd0};
        vt[10] = '{1'b1, 1'b1, 0, 5, 2'd0};
        vt[11] = '{1'b1, 1'b1, 0, 6, 2'd0};
        vt[12] = '{1'b1, 1'b1, 0, 7, 2'd1};
        vt[13] = '{1'b1, 1'b1, 1, 2, 2'd1};
        vt[14] = '{1'b1, 1'b1, 1, 3, 2'd2};
        vt[15] = '{1'b1, 1'b1, 2, 2, 2'd2};
        vt[16] = '{1'b1, 1'b1, 2, 3, 2'd0};

        // Reset with every input valid, then saturated weighted rounds.
        clear_src();
        for (int i = 0; i < 3; i++) rem[0][i] = 1000;
        bus0.out_a = 1'b1;
        bus1.out_a = 1'b1;
        drive();
        for (int c = 0; c < 3; c++) begin
            cycle();
            check($sformatf("rst%0d acks", c), ack0, 3'b000);
            check($sformatf("rst%0d grant", c), bus0.grant, 2'd3);
            check($sformatf("rst%0d out_v", c), bus0.out_v, 1'b0);
        end
        check("rst out_d", bus0.out_d, '0);
        reset = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus0.out_a = vt[i].out_a;
            cycle();
            check($sformatf("sat%0d out_v", i), bus0.out_v, vt[i].exp_v);
            if (vt[i].exp_v)
                check($sformatf("sat%0d out_d", i), bus0.out_d, mk(vt[i].src, 8'h00, vt[i].seq));
            check($sformatf("sat%0d grant", i), bus0.grant, vt[i].gnt);
        end

        // Output backpressure mid-burst holding the special BD word.
        do_reset();
        rem[0][0] = 1000;
        rem[0][1] = 1000;
        spec_seq  = 2;
        drive();
        reset = 1'b1;
        repeat (4) cycle();
        check("bp loaded", bus0.out_d, special);
        bus0.out_a = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cycle();
            check($sformatf("bp%0d acks", c), ack0, 3'b000);
            check($sformatf("bp%0d out_d", c), bus0.out_d, special);
            check($sformatf("bp%0d out_v", c), bus0.out_v, 1'b1);
            check($sformatf("bp%0d grant", c), bus0.grant, 2'd0);
        end
        bus0.out_a = 1'b1;
        cycle();
        check("bp last bd", bus0.out_d, mk(0, 8'h00, 3));
        check("bp rotate", bus0.grant, 2'd1);
        cycle();
        check("bp fpga", bus0.out_d, mk(1, 8'h00, 0));

        // Single requester: Global only, ten back-to-back words.
        do_reset();
        rem[0][2] = 10;
        drive();
        reset = 1'b1;
        cycle();
        check("single grant", bus0.grant, 2'd2);
        for (int k = 0; k < 10; k++) begin
            cycle();
            check($sformatf("single%0d xfer", k), tk0, 3'b100);
            check($sformatf("single%0d out_d", k), bus0.out_d, mk(2, 8'h00, k));
        end
        cycle();
        check("single drain out_v", bus0.out_v, 1'b0);
        check("single idle grant", bus0.grant, 2'd3);

        // FPGA valid drops between the two halves of a code-14 pair.
        do_reset();
        rem[0][0] = 1000;
        rem[0][1] = 2;
        fq0.push_back(8'd14);
        fq0.push_back(8'd14);
        drive();
        reset = 1'b1;
        repeat (6) cycle();
        check("starve first half", bus0.out_d, mk(1, 8'd14, 0));
        check("starve grant", bus0.grant, 2'd1);
        hold = 1'b1;
        drive();
        for (int c = 0; c < 5; c++) begin
            cycle();
            check($sformatf("starve%0d grant", c), bus0.grant, 2'd1);
            check($sformatf("starve%0d bd_a", c), ack0[0], 1'b0);
            check($sformatf("starve%0d xfer", c), tk0, 3'b000);
        end
        hold = 1'b0;
        drive();
        cycle();
        check("starve second half", bus0.out_d, mk(1, 8'd14, 1));
        check("starve rotate", bus0.grant, 2'd0);
        cycle();
        check("starve next bd", bus0.out_d, mk(0, 8'h00, 4));

        // Pair lock with a one-word FPGA credit on the second instance.
        do_reset();
        rem[1][0] = 1000;
        rem[1][1] = 6;
        fq1.push_back(8'd13); fq1.push_back(8'd13);
        fq1.push_back(8'd14); fq1.push_back(8'd14);
        fq1.push_back(8'd14); fq1.push_back(8'd14);
        drive();
        reset = 1'b1;
        for (int b = 0; b < 4; b++) expw.push_back(mk(0, 8'h00, b));
        expw.push_back(mk(1, 8'd13, 0));
        expw.push_back(mk(1, 8'd13, 1));
        for (int b = 4; b < 8; b++) expw.push_back(mk(0, 8'h00, b));
        expw.push_back(mk(1, 8'd14, 2));
        expw.push_back(mk(1, 8'd14, 3));
        for (int b = 8; b < 12; b++) expw.push_back(mk(0, 8'h00, b));
        expw.push_back(mk(1, 8'd14, 4));
        expw.push_back(mk(1, 8'd14, 5));
        for (int c = 0; c < 19; c++) begin
            cycle();
            if (bus1.out_v) got.push_back(bus1.out_d);
        end
        check("pair count", got.size(), 18);
        for (int i = 0; i < 18; i++) begin
            if (i < got.size())
                check($sformatf("pair word %0d", i), got[i], expw[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
